// File: rtl/stv_aes_round_mix.sv
// AES round datapath: (Inv)ShiftRows, (Inv)MixColumns one column per cycle, optional AddRoundKey.
// Define STV_AES_ROUND_ADDKEY_EN to capture round_key and XOR it into out_state.

module stv_aes_mixcolumn (
  input  logic [31:0] col_in,
  input  logic        inverse,
  output logic [31:0] col_out
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] u, v;
  logic [7:0] t;

  // InvMixColumns = MixColumns applied after a cheap pre-mix of opposite bytes.
  always_comb begin
    a0 = col_in[7:0];
    a1 = col_in[15:8];
    a2 = col_in[23:16];
    a3 = col_in[31:24];
    u  = 8'h00;
    v  = 8'h00;
    if (inverse) begin
      u  = xt(xt(a0 ^ a2));
      v  = xt(xt(a1 ^ a3));
      a0 = a0 ^ u;
      a1 = a1 ^ v;
      a2 = a2 ^ u;
      a3 = a3 ^ v;
    end
    t = a0 ^ a1 ^ a2 ^ a3;
    col_out[7:0]   = a0 ^ t ^ xt(a0 ^ a1);
    col_out[15:8]  = a1 ^ t ^ xt(a1 ^ a2);
    col_out[23:16] = a2 ^ t ^ xt(a2 ^ a3);
    col_out[31:24] = a3 ^ t ^ xt(a3 ^ a0);
  end

endmodule

module stv_aes_round_mix (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         inverse,
  input  logic         last,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and out_state holds until taken.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MIX  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] buf_q, buf_d;
  logic         inv_q, inv_d;
  logic [31:0]  mix_in;
  logic [31:0]  mix_out;
  logic [127:0] key_val;

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
      end
    end
    return o;
  endfunction

  assign mix_in = buf_q[{col_q, 5'd0} +: 32];

  stv_aes_mixcolumn u_mix (
    .col_in  (mix_in),
    .inverse (inv_q),
    .col_out (mix_out)
  );

`ifdef STV_AES_ROUND_ADDKEY_EN
  logic [127:0] key_q, key_d;

  always_comb begin
    key_d = key_q;
    if (state_q == S_IDLE && in_valid) begin
      key_d = round_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
    end else begin
      key_q <= key_d;
    end
  end

  assign key_val = key_q;
`else
  logic unused_round_key;
  assign unused_round_key = ^round_key;
  assign key_val = '0;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    buf_d   = buf_q;
    inv_d   = inv_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          buf_d   = shift_rows(in_state, inverse);
          inv_d   = inverse;
          col_d   = 2'd0;
          state_d = last ? S_DONE : S_MIX;
        end
      end
      S_MIX: begin
        buf_d[{col_q, 5'd0} +: 32] = mix_out;
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= 2'd0;
      buf_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
      inv_q   <= inv_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_state = out_valid ? (buf_q ^ key_val) : '0;

endmodule
